// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_pkg
// Purpose  : Shared types and constants for the load/store unit: FSM state
//            encoding, RV32I load/store funct3 and opcode constants, and the
//            access legality check used at command capture.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    // RV32I major opcodes that feed this unit through control_unit
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // Access size / sign encodings carried in funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // An access is legal when exactly one direction is requested, the funct3
    // exists for that direction, and the address is naturally aligned.
    function automatic logic lsu_access_legal(
        input logic       rd,
        input logic       wr,
        input logic [2:0] f3,
        input logic [1:0] byte_off
    );
        logic f3_ok;
        logic aligned;
        if (rd) begin
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        end else begin
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        case (f3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~byte_off[0];
            2'b10:   aligned = (byte_off == 2'b00);
            default: aligned = 1'b0;
        endcase
        return ~(rd & wr) & f3_ok & aligned;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Combinational data steering for the load/store unit.
//            Stores: byte enables and replicated store data per size/offset.
//            Loads : byte/half extraction by offset with sign/zero extension.
// Ports    : is_load     - 1 = load access (byte enables forced to 1111)
//            funct3      - access size/sign
//            byte_off    - addr[1:0]
//            store_data  - raw rs2 value
//            load_word   - raw 32-bit bus read word
//            be          - byte enables for the bus
//            store_lanes - lane-replicated store data
//            load_data   - extended load result
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic        is_load,
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Replicating the datum into every lane lets the memory pick whichever
    // lane the byte enables select, with no shifter needed here.
    always_comb begin
        be          = 4'b1111;
        store_lanes = store_data;
        if (!is_load) begin
            case (funct3[1:0])
                2'b00: begin
                    be          = 4'b0001 << byte_off;
                    store_lanes = {4{store_data[7:0]}};
                end
                2'b01: begin
                    be          = 4'b0011 << byte_off;
                    store_lanes = {2{store_data[15:0]}};
                end
                default: begin
                    be          = 4'b1111;
                    store_lanes = store_data;
                end
            endcase
        end
    end

    always_comb begin
        case (byte_off)
            2'd0:    w_byte = load_word[7:0];
            2'd1:    w_byte = load_word[15:8];
            2'd2:    w_byte = load_word[23:16];
            default: w_byte = load_word[31:24];
        endcase
        w_half = byte_off[1] ? load_word[31:16] : load_word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    load_data = {{16{w_half[15]}}, w_half};
            F3_BU:   load_data = {24'd0, w_byte};
            F3_HU:   load_data = {16'd0, w_half};
            default: load_data = load_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : MEM-stage data-memory initiator. Captures a load/store command,
//            checks legality, runs the req/ready + rvalid bus handshake,
//            extends load data and retires with a one-cycle done pulse.
//            Misaligned/illegal accesses and bus timeouts retire with err=1.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            valid, mem_read, mem_write, funct3, addr, wdata - command in
//            stall                    - pipeline hold (combinational)
//            done, err, rdata         - retirement outputs
//            dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be - bus request
//            dmem_ready, dmem_rvalid, dmem_rdata                - bus response
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam int              c_cnt_w   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'(TIMEOUT - 1);

    lsu_state_e         r_state;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [2:0]         r_f3;
    logic               r_is_load;
    logic               r_err;
    logic [31:0]        r_rdata;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_start;
    logic               w_legal;
    logic               w_to_hit;
    logic               w_in_req;
    logic [3:0]         w_be;
    logic [31:0]        w_lanes;
    logic [31:0]        w_ext;

    assign w_start  = valid & (mem_read | mem_write);
    assign w_legal  = lsu_access_legal(mem_read, mem_write, funct3, addr[1:0]);
    // A zero TIMEOUT disables the watchdog entirely.
    assign w_to_hit = (TIMEOUT != 0) && (r_cnt == c_to_last);
    assign w_in_req = (r_state == ST_REQ);

    lsu_align u_align (
        .is_load     (r_is_load),
        .funct3      (r_f3),
        .byte_off    (r_addr[1:0]),
        .store_data  (r_wdata),
        .load_word   (dmem_rdata),
        .be          (w_be),
        .store_lanes (w_lanes),
        .load_data   (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_f3      <= 3'd0;
            r_is_load <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= 32'd0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_addr    <= addr;
                        r_wdata   <= wdata;
                        r_f3      <= funct3;
                        r_is_load <= mem_read & ~mem_write;
                        r_cnt     <= '0;
                        r_err     <= ~w_legal;
                        if (w_legal) begin
                            r_state <= ST_REQ;
                        end else begin
                            r_rdata <= 32'd0;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    // Acceptance wins over a coincident timeout.
                    if (dmem_ready) begin
                        r_cnt   <= '0;
                        r_state <= r_is_load ? ST_RESP : ST_DONE;
                    end else if (w_to_hit) begin
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (dmem_rvalid) begin
                        r_rdata <= w_ext;
                        r_state <= ST_DONE;
                    end else if (w_to_hit) begin
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall      = ((r_state == ST_IDLE) & w_start) | w_in_req | (r_state == ST_RESP);
    assign done       = (r_state == ST_DONE);
    assign err        = done & r_err;
    assign rdata      = r_rdata;

    // Bus fields are driven only while a request is outstanding so the bus
    // sees all-zero outside REQ.
    assign dmem_req   = w_in_req;
    assign dmem_we    = w_in_req & ~r_is_load;
    assign dmem_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign dmem_wdata = (w_in_req & ~r_is_load) ? w_lanes : 32'd0;
    assign dmem_be    = w_in_req ? w_be : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Scoreboard bench for load_store_unit. Stimulus pushes expected
//            bus requests and retirements; a monitor compares on each falling
//            clock edge whenever the DUT requests the bus or retires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, err;
    logic [31:0] rdata;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_be     (dmem_be),
        .dmem_ready  (dmem_ready),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic        chk_rdata;
        logic [31:0] rdata;
        int          lat;
        int          t0;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    resp_t rq[$];
    bus_t  bq[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic model_legal(input logic rd, input logic wr,
                                         input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (rd && wr) return 1'b0;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
        size = 1 << f3[1:0];
        return (int'(a[1:0]) % size) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] word);
        logic [31:0] w, x;
        w = word >> (8 * int'(a[1:0]));
        case (f3)
            3'd0: begin x = w & 32'hFF;   if (x > 127)   x = x - 32'd256;   end
            3'd1: begin x = w & 32'hFFFF; if (x > 32767) x = x - 32'd65536; end
            3'd4: x = w & 32'hFF;
            3'd5: x = w & 32'hFFFF;
            default: x = word;
        endcase
        return x;
    endfunction

    function automatic bus_t model_bus(input logic rd, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] wd);
        bus_t b;
        b.we    = !rd;
        b.addr  = a & 32'hFFFF_FFFC;
        b.be    = 4'b1111;
        b.wdata = wd;
        if (!rd && f3 == 3'd0) begin
            b.be    = 4'(1 << int'(a[1:0]));
            b.wdata = (wd & 32'hFF) * 32'h0101_0101;
        end else if (!rd && f3 == 3'd1) begin
            b.be    = 4'(3 << int'(a[1:0]));
            b.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
        end
        return b;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (dmem_req) begin
                if (bq.size() == 0) begin
                    chk("unexpected_req", 32'(dmem_req), 32'd0);
                end else begin
                    chk("bus_we",   32'(dmem_we), 32'(bq[0].we));
                    chk("bus_addr", dmem_addr,    bq[0].addr);
                    chk("bus_be",   32'(dmem_be), 32'(bq[0].be));
                    if (bq[0].we) chk("bus_wdata", dmem_wdata, bq[0].wdata);
                    if (dmem_ready) void'(bq.pop_front());
                end
            end
            if (done) begin
                if (rq.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    resp_t r;
                    r = rq.pop_front();
                    chk("err", 32'(err), 32'(r.err));
                    if (r.err || r.chk_rdata) chk("rdata", rdata, r.rdata);
                    chk("latency", 32'(cyc - r.t0), 32'(r.lat));
                    chk("stall_at_done", 32'(stall), 32'd0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else chk("stall_busy", 32'(stall), 32'd1);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_wait: no done within %0d cycles", budget);
            rq.delete();
            bq.delete();
        end
        @(posedge clk); #1;
    endtask

    // mode 0: normal handshake, 1: ready never comes, 2: rvalid never comes
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                         input int rdly, input int vdly, input logic stray, input int mode);
        logic  lg;
        resp_t r;
        lg          = model_legal(rd, wr, f3, a);
        r.err       = !lg || (mode != 0);
        r.chk_rdata = lg && rd;
        r.rdata     = r.err ? 32'd0 : model_load(f3, a, rw);
        if (!lg)            r.lat = 1;
        else if (mode == 1) r.lat = 1 + TO;
        else if (mode == 2) r.lat = 2 + TO;
        else if (rd)        r.lat = rdly + vdly + 3;
        else                r.lat = rdly + 2;
        r.t0 = cyc;
        rq.push_back(r);
        if (lg) bq.push_back(model_bus(rd, f3, a, wd));

        valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        chk("stall_start", 32'(stall), 32'd1);
        @(posedge clk); #1;
        valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
        if (lg && mode != 1) begin
            repeat (rdly) begin @(posedge clk); #1; end
            dmem_ready = 1'b1;
            if (stray && rd) begin dmem_rvalid = 1'b1; dmem_rdata = ~rw; end
            @(posedge clk); #1;
            dmem_ready = 1'b0; dmem_rvalid = 1'b0;
            if (rd && mode == 0) begin
                repeat (vdly) begin @(posedge clk); #1; end
                dmem_rvalid = 1'b1; dmem_rdata = rw;
                @(posedge clk); #1;
                dmem_rvalid = 1'b0; dmem_rdata = $urandom;
            end
        end
        wait_done(40);
        if (mode == 1) bq.delete();
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_err",   32'(err),   32'd0);
        chk("rst_rdata", rdata,      32'd0);
        chk("rst_req",   32'({dmem_req, dmem_we, dmem_be}), 32'd0);
        chk("rst_bus",   dmem_addr | dmem_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        do_op(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0, 0);    // SW
        do_op(1'b1, 1'b0, 3'd0, 32'h203, 32'h0, 32'h80FF_1234, 0, 2, 1'b1, 0);   // LB
        do_op(1'b1, 1'b0, 3'd5, 32'h202, 32'h0, 32'h80FF_1234, 1, 0, 1'b0, 0);   // LHU
        do_op(1'b0, 1'b1, 3'd1, 32'h202, 32'h0000_ABCD, 32'h0, 2, 0, 1'b0, 0);   // SH
        do_op(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0, 0);           // LW misaligned
        do_op(1'b1, 1'b1, 3'd2, 32'h100, 32'h0, 32'h0, 0, 0, 1'b0, 0);           // both commands
        do_op(1'b1, 1'b0, 3'd2, 32'h400, 32'h0, 32'h1234_5678, 0, 0, 1'b0, 0);   // LW -> nonzero rdata
        do_op(1'b1, 1'b0, 3'd2, 32'h404, 32'h0, 32'h0, 0, 0, 1'b0, 2);           // RESP timeout
        chk("req_after_to", 32'(dmem_req), 32'd0);
        do_op(1'b0, 1'b1, 3'd0, 32'h405, 32'h77, 32'h0, 0, 0, 1'b0, 1);          // REQ timeout
        chk("req_after_to2", 32'(dmem_req), 32'd0);

        // Reset while waiting in RESP, with rvalid in the same cycle
        do_op(1'b1, 1'b0, 3'd2, 32'h500, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0, 0);
        rq.push_back('{err: 1'b0, chk_rdata: 1'b1, rdata: 32'h0, lat: 0, t0: 0});
        bq.push_back(model_bus(1'b1, 3'd2, 32'h600, 32'h0));
        valid = 1'b1; mem_read = 1'b1; funct3 = 3'd2; addr = 32'h600;
        @(posedge clk); #1;
        valid = 1'b0; mem_read = 1'b0; dmem_ready = 1'b1;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        rq.delete();  // the access must never retire
        rst = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        rst = 1'b0; dmem_rvalid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_resp_done",  32'(done),     32'd0);
            chk("rst_resp_req",   32'(dmem_req), 32'd0);
            chk("rst_resp_rdata", rdata,         32'd0);
        end
        @(posedge clk); #1;

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            logic        rd, wr, stray;
            logic [2:0]  f3;
            logic [31:0] a;
            rd = 1'($urandom_range(0, 1));
            wr = !rd;
            if ($urandom_range(0, 15) == 0) begin rd = 1'b1; wr = 1'b1; end
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                if (rd) f3 = 3'($urandom_range(0, 4)) + (($urandom_range(0, 4) > 2) ? 3'd0 : 3'd0);
                if (rd && f3 == 3'd3) f3 = 3'd4;
                if (rd && f3 > 3'd4 && f3 != 3'd5) f3 = 3'd5;
                if (!rd) f3 = 3'($urandom_range(0, 2));
            end
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            stray = 1'($urandom_range(0, 1));
            do_op(rd, wr, f3, a, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), stray, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
